// File: rtl/i2c_globals_pkg.sv
// i2c_globals_pkg: shared widths, command/status encodings and FSM state codes
// for the I2C master transfer controller and its command issuer.
package i2c_globals_pkg;

    localparam int I2C_SLAVE_ADDRESS_WIDTH    = 7;
    localparam int I2C_REGISTER_ADDRESS_WIDTH = 8;
    localparam int I2C_DATA_WIDTH             = 8;
    localparam int I2C_MAXIMUM_BYTES          = 128;
    localparam int I2C_LEN_WIDTH              = 8;
    localparam int I2C_STATE_WIDTH            = 4;

    typedef enum logic {
        RW_WRITE = 1'b0,
        RW_READ  = 1'b1
    } read_write_e;

    typedef enum logic [2:0] {
        OP_START   = 3'd0,
        OP_RESTART = 3'd1,
        OP_WRITE   = 3'd2,
        OP_READ    = 3'd3,
        OP_STOP    = 3'd4
    } i2c_ctrl_op_e;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_ADDR_NACK = 3'd1,
        ST_REG_NACK  = 3'd2,
        ST_DATA_NACK = 3'd3,
        ST_LEN_ERR   = 3'd4
    } i2c_ctrl_status_e;

    // Transfer FSM state enumeration, kept as plain constants for legacy tools.
    localparam logic [I2C_STATE_WIDTH-1:0] S_IDLE    = 4'd0;
    localparam logic [I2C_STATE_WIDTH-1:0] S_START   = 4'd1;
    localparam logic [I2C_STATE_WIDTH-1:0] S_ADDR_W  = 4'd2;
    localparam logic [I2C_STATE_WIDTH-1:0] S_REG     = 4'd3;
    localparam logic [I2C_STATE_WIDTH-1:0] S_WDATA   = 4'd4;
    localparam logic [I2C_STATE_WIDTH-1:0] S_RESTART = 4'd5;
    localparam logic [I2C_STATE_WIDTH-1:0] S_ADDR_R  = 4'd6;
    localparam logic [I2C_STATE_WIDTH-1:0] S_RDATA   = 4'd7;
    localparam logic [I2C_STATE_WIDTH-1:0] S_STOP    = 4'd8;
    localparam logic [I2C_STATE_WIDTH-1:0] S_DONE    = 4'd9;

endpackage

// File: rtl/i2c_cmd_issuer.sv
// i2c_cmd_issuer: holds one byte-engine command until accepted, then waits for its response.
//   issue / issue_*      load a new command (only while idle or on rsp_done)
//   cmd_*  / cmd_ready   command handshake towards the byte engine, held stable until ready
//   rsp_valid            engine response; only honoured while a command is outstanding
//   rsp_done             response for the outstanding command arrived this cycle
//   idle                 no command pending or outstanding (issue phase)
module i2c_cmd_issuer
    import i2c_globals_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH
) (
    input  logic                  pclk,
    input  logic                  areset_n,
    input  logic                  issue,
    input  logic [2:0]            issue_op,
    input  logic [DATA_WIDTH-1:0] issue_tx_byte,
    input  logic                  issue_master_nack,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_op,
    output logic [DATA_WIDTH-1:0] cmd_tx_byte,
    output logic                  cmd_master_nack,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    output logic                  rsp_done,
    output logic                  idle
);

    logic waiting;

    assign rsp_done = waiting && rsp_valid;
    assign idle     = !cmd_valid && !waiting;

    // A new command may be loaded in the same cycle the previous response retires.
    always_ff @(posedge pclk or negedge areset_n) begin
        if (!areset_n) begin
            cmd_valid       <= 1'b0;
            cmd_op          <= OP_START;
            cmd_tx_byte     <= '0;
            cmd_master_nack <= 1'b0;
            waiting         <= 1'b0;
        end else begin
            if (issue) begin
                cmd_valid       <= 1'b1;
                cmd_op          <= issue_op;
                cmd_tx_byte     <= issue_tx_byte;
                cmd_master_nack <= issue_master_nack;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                waiting   <= 1'b1;
            end
            if (rsp_done)
                waiting <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_master_xfer_ctrl.sv
// i2c_master_xfer_ctrl: sequences an I2C register write/read transfer as byte-engine commands.
//   req_*            transfer request (slave address, direction, register, length)
//   wdata_*          write-byte stream, consumed one byte per data WRITE
//   rdata_valid/rdata  read bytes, forwarded in the cycle the engine returns them
//   done/status      one-cycle completion pulse with result code
//   cmd_* / rsp_*    one-outstanding-command interface to the byte engine
module i2c_master_xfer_ctrl
    import i2c_globals_pkg::*;
#(
    parameter int SLAVE_ADDRESS_WIDTH    = I2C_SLAVE_ADDRESS_WIDTH,
    parameter int REGISTER_ADDRESS_WIDTH = I2C_REGISTER_ADDRESS_WIDTH,
    parameter int DATA_WIDTH             = I2C_DATA_WIDTH,
    parameter int MAXIMUM_BYTES          = I2C_MAXIMUM_BYTES
) (
    input  logic                              pclk,
    input  logic                              areset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [SLAVE_ADDRESS_WIDTH-1:0]    req_slave_address,
    input  logic                              req_read_write,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] req_register_address,
    input  logic [I2C_LEN_WIDTH-1:0]          req_len,
    input  logic                              wdata_valid,
    output logic                              wdata_ready,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic                              rdata_valid,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              done,
    output logic [2:0]                        status,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic [2:0]                        cmd_op,
    output logic [DATA_WIDTH-1:0]             cmd_tx_byte,
    output logic                              cmd_master_nack,
    input  logic                              rsp_valid,
    input  logic [DATA_WIDTH-1:0]             rsp_rx_byte,
    input  logic                              rsp_ack
);

    localparam logic [I2C_LEN_WIDTH-1:0] ONE = I2C_LEN_WIDTH'(1);
    localparam logic [I2C_LEN_WIDTH-1:0] TWO = I2C_LEN_WIDTH'(2);

    logic [I2C_STATE_WIDTH-1:0]        state, state_d;
    logic [SLAVE_ADDRESS_WIDTH-1:0]    addr_q;
    logic                              rw_q;
    logic [REGISTER_ADDRESS_WIDTH-1:0] reg_q;
    logic [I2C_LEN_WIDTH-1:0]          cnt_q, cnt_d, cnt_dec;
    i2c_ctrl_status_e                  status_q, status_d;
    logic                              issue, iss_nack, go_stop, iss_idle, rsp_done;
    i2c_ctrl_op_e                      iss_op;
    logic [DATA_WIDTH-1:0]             iss_byte, addr_wr, addr_rd, reg_byte;

    assign addr_wr  = DATA_WIDTH'({addr_q, 1'b0});
    assign addr_rd  = DATA_WIDTH'({addr_q, 1'b1});
    assign reg_byte = DATA_WIDTH'(reg_q);
    assign cnt_dec  = (cnt_q != '0) ? cnt_q - ONE : '0;

    assign req_ready   = state == S_IDLE;
    assign wdata_ready = state == S_WDATA && iss_idle;
    assign rdata_valid = state == S_RDATA && rsp_done;
    assign rdata       = rdata_valid ? rsp_rx_byte : '0;
    assign done        = state == S_DONE;
    assign status      = done ? status_q : ST_OK;

    // Each command state's command is issued on the edge that enters it, so the
    // wait phase of one state overlaps the issue of the next. WDATA is the
    // exception: its WRITE waits for the write-stream handshake.
    always_comb begin
        state_d  = state;
        status_d = status_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;
        iss_op   = OP_START;
        iss_byte = '0;
        iss_nack = 1'b0;
        go_stop  = 1'b0;
        case (state)
            S_IDLE: if (req_valid) begin
                cnt_d = req_len;
                if (int'(req_len) > MAXIMUM_BYTES) begin
                    state_d  = S_DONE;
                    status_d = ST_LEN_ERR;
                end else begin
                    state_d  = S_START;
                    status_d = ST_OK;
                    issue    = 1'b1;
                end
            end
            S_START: if (rsp_done) begin
                state_d  = S_ADDR_W;
                issue    = 1'b1;
                iss_op   = OP_WRITE;
                iss_byte = addr_wr;
            end
            S_ADDR_W: if (rsp_done) begin
                if (rsp_ack) begin
                    status_d = ST_ADDR_NACK;
                    go_stop  = 1'b1;
                end else begin
                    state_d  = S_REG;
                    issue    = 1'b1;
                    iss_op   = OP_WRITE;
                    iss_byte = reg_byte;
                end
            end
            S_REG: if (rsp_done) begin
                if (rsp_ack) begin
                    status_d = ST_REG_NACK;
                    go_stop  = 1'b1;
                end else if (cnt_q == '0) begin
                    go_stop = 1'b1;
                end else if (rw_q == RW_READ) begin
                    state_d = S_RESTART;
                    issue   = 1'b1;
                    iss_op  = OP_RESTART;
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WDATA: if (iss_idle && wdata_valid) begin
                issue    = 1'b1;
                iss_op   = OP_WRITE;
                iss_byte = wdata;
            end else if (rsp_done) begin
                cnt_d = cnt_dec;
                if (rsp_ack) begin
                    status_d = ST_DATA_NACK;
                    go_stop  = 1'b1;
                end else if (cnt_q <= ONE) begin
                    go_stop = 1'b1;
                end
            end
            S_RESTART: if (rsp_done) begin
                state_d  = S_ADDR_R;
                issue    = 1'b1;
                iss_op   = OP_WRITE;
                iss_byte = addr_rd;
            end
            S_ADDR_R: if (rsp_done) begin
                if (rsp_ack) begin
                    status_d = ST_ADDR_NACK;
                    go_stop  = 1'b1;
                end else begin
                    state_d  = S_RDATA;
                    issue    = 1'b1;
                    iss_op   = OP_READ;
                    iss_nack = cnt_q == ONE;
                end
            end
            S_RDATA: if (rsp_done) begin
                cnt_d = cnt_dec;
                if (cnt_q <= ONE) begin
                    go_stop = 1'b1;
                end else begin
                    issue    = 1'b1;
                    iss_op   = OP_READ;
                    iss_nack = cnt_q == TWO;
                end
            end
            S_STOP: if (rsp_done) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_stop) begin
            state_d = S_STOP;
            issue   = 1'b1;
            iss_op  = OP_STOP;
        end
    end

    always_ff @(posedge pclk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
            cnt_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            reg_q    <= '0;
        end else begin
            state    <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            if (state == S_IDLE && req_valid) begin
                addr_q <= req_slave_address;
                rw_q   <= req_read_write;
                reg_q  <= req_register_address;
            end
        end
    end

    i2c_cmd_issuer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_issuer (
        .pclk             (pclk),
        .areset_n         (areset_n),
        .issue            (issue),
        .issue_op         (iss_op),
        .issue_tx_byte    (iss_byte),
        .issue_master_nack(iss_nack),
        .cmd_valid        (cmd_valid),
        .cmd_op           (cmd_op),
        .cmd_tx_byte      (cmd_tx_byte),
        .cmd_master_nack  (cmd_master_nack),
        .cmd_ready        (cmd_ready),
        .rsp_valid        (rsp_valid),
        .rsp_done         (rsp_done),
        .idle             (iss_idle)
    );

endmodule

// File: tb/tb_i2c_master_xfer_ctrl.sv
// tb_i2c_master_xfer_ctrl: directed scenarios against a simple byte-engine model.
module tb_i2c_master_xfer_ctrl;
    import i2c_globals_pkg::*;

    logic       pclk = 1'b0, areset_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_read_write = 1'b0;
    logic [6:0] req_slave_address = '0;
    logic [7:0] req_register_address = '0, req_len = '0;
    logic       wdata_valid = 1'b0, wdata_ready, rdata_valid, done;
    logic [7:0] wdata = '0, rdata, cmd_tx_byte, rsp_rx_byte = '0;
    logic [2:0] status, cmd_op;
    logic       cmd_valid, cmd_ready = 1'b1, cmd_master_nack, rsp_valid = 1'b0, rsp_ack = 1'b0;

    int vectors = 0, miscompares = 0;

    logic [2:0] op_log[0:31];
    logic [7:0] byte_log[0:31];
    logic       nack_log[0:31];
    logic       ack_tbl[0:31];
    logic [7:0] rx_tbl[0:31];
    logic [7:0] rd_log[0:7];
    logic [7:0] wq[0:7];
    logic [2:0] exp_op[0:31];
    logic [7:0] exp_byte[0:31];
    logic [2:0] last_status;
    int n_cmds = 0, n_rd = 0, done_cnt = 0, wr_n = 0, wr_idx = 0, exp_n = 0, rcnt = 0;
    bit wr_en = 1'b0, hs = 1'b0;

    always #5 pclk = ~pclk;

    i2c_master_xfer_ctrl dut (
        .pclk(pclk), .areset_n(areset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_slave_address(req_slave_address), .req_read_write(req_read_write),
        .req_register_address(req_register_address), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .status(status),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_tx_byte(cmd_tx_byte), .cmd_master_nack(cmd_master_nack),
        .rsp_valid(rsp_valid), .rsp_rx_byte(rsp_rx_byte), .rsp_ack(rsp_ack)
    );

    // Byte-engine and stream model: observe at negedge, drive just after posedge.
    // Each accepted command gets its response two cycles after the handshake.
    initial begin
        forever begin
            @(negedge pclk);
            if (areset_n) begin
                if (rdata_valid && n_rd < 8) begin rd_log[n_rd] = rdata; n_rd++; end
                if (done) begin done_cnt++; last_status = status; end
                if (cmd_valid && cmd_ready && n_cmds < 32) begin
                    op_log[n_cmds] = cmd_op; byte_log[n_cmds] = cmd_tx_byte;
                    nack_log[n_cmds] = cmd_master_nack; n_cmds++; hs = 1'b1;
                end
                if (wdata_valid && wdata_ready) wr_idx++;
            end
            @(posedge pclk); #1;
            rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_rx_byte = '0;
            if (hs) begin
                hs = 1'b0; rcnt = 1;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    rsp_valid = 1'b1; rsp_ack = ack_tbl[n_cmds-1]; rsp_rx_byte = rx_tbl[n_cmds-1];
                end
            end
            wdata_valid = wr_en && wr_idx < wr_n;
            wdata = (wr_idx < wr_n) ? wq[wr_idx] : 8'h00;
        end
    end

    task automatic clear_logs();
        n_cmds = 0; n_rd = 0; done_cnt = 0; wr_idx = 0; wr_n = 0; exp_n = 0;
        for (int i = 0; i < 32; i++) begin
            op_log[i] = 3'h7; byte_log[i] = 8'hxx; nack_log[i] = 1'bx;
            ack_tbl[i] = 1'b0; rx_tbl[i] = 8'h00;
        end
    endtask

    task automatic exp_add(input logic [2:0] op, input logic [7:0] b);
        exp_op[exp_n] = op; exp_byte[exp_n] = b; exp_n++;
    endtask

    task automatic start_req(input logic [6:0] a, input logic rw, input logic [7:0] r, input logic [7:0] len);
        bit ok = 1'b0;
        @(posedge pclk); #2;
        req_slave_address = a; req_read_write = rw; req_register_address = r; req_len = len;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge pclk);
            ok = req_ready;
        end
        @(posedge pclk); #2;
        req_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL req_accept: req_ready never seen high");
        end
    endtask

    task automatic wait_done(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge pclk);
            ok = done_cnt >= target;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: done_cnt=%0d want %0d", done_cnt, target);
        end
        repeat (3) @(posedge pclk);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || done !== 1'b0 || wdata_ready !== 1'b0 ||
            rdata_valid !== 1'b0 || cmd_op !== 3'd0 || status !== 3'd0 || cmd_tx_byte !== 8'h00 ||
            cmd_master_nack !== 1'b0 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: rr=%b cv=%b dn=%b wr=%b rv=%b op=%0d st=%0d want rr=1 others 0",
                     req_ready, cmd_valid, done, wdata_ready, rdata_valid, cmd_op, status);
        end
        @(posedge pclk); #3;
        areset_n = 1'b1;
        repeat (2) @(posedge pclk);
    endtask

    task automatic test_write();
        clear_logs();
        wq[0] = 8'hA5; wq[1] = 8'h3C; wr_n = 2; wr_en = 1'b1;
        cmd_ready = 1'b0;
        start_req(7'h68, 1'b0, 8'h10, 8'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_op !== 3'd0) begin
                miscompares++;
                $display("FAIL write_start_hold%0d: cmd_valid=%b op=%0d want 1/0", i, cmd_valid, cmd_op);
            end
        end
        @(posedge pclk); #2;
        cmd_ready = 1'b1;
        wait_done(1);
        exp_add(OP_START, 8'h00); exp_add(OP_WRITE, 8'hD0); exp_add(OP_WRITE, 8'h10);
        exp_add(OP_WRITE, 8'hA5); exp_add(OP_WRITE, 8'h3C); exp_add(OP_STOP, 8'h00);
        vectors++;
        if (n_cmds !== exp_n) begin
            miscompares++; $display("FAIL write_ncmds: got %0d want %0d", n_cmds, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if (op_log[i] !== exp_op[i] || (exp_op[i] == OP_WRITE && byte_log[i] !== exp_byte[i])) begin
                miscompares++;
                $display("FAIL write_cmd%0d: got op=%0d byte=%h want op=%0d byte=%h",
                         i, op_log[i], byte_log[i], exp_op[i], exp_byte[i]);
            end
        end
        vectors++;
        if (done_cnt !== 1 || last_status !== 3'd0) begin
            miscompares++; $display("FAIL write_done: cnt=%0d status=%0d want 1/0", done_cnt, last_status);
        end
    endtask

    task automatic test_read();
        clear_logs();
        rx_tbl[5] = 8'h11; rx_tbl[6] = 8'h22; rx_tbl[7] = 8'h33;
        start_req(7'h4C, 1'b1, 8'h02, 8'd3);
        wait_done(1);
        exp_add(OP_START, 8'h00); exp_add(OP_WRITE, 8'h98); exp_add(OP_WRITE, 8'h02);
        exp_add(OP_RESTART, 8'h00); exp_add(OP_WRITE, 8'h99); exp_add(OP_READ, 8'h00);
        exp_add(OP_READ, 8'h00); exp_add(OP_READ, 8'h00); exp_add(OP_STOP, 8'h00);
        vectors++;
        if (n_cmds !== exp_n) begin
            miscompares++; $display("FAIL read_ncmds: got %0d want %0d", n_cmds, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if (op_log[i] !== exp_op[i] || (exp_op[i] == OP_WRITE && byte_log[i] !== exp_byte[i])) begin
                miscompares++;
                $display("FAIL read_cmd%0d: got op=%0d byte=%h want op=%0d byte=%h",
                         i, op_log[i], byte_log[i], exp_op[i], exp_byte[i]);
            end
        end
        vectors++;
        if (nack_log[5] !== 1'b0 || nack_log[6] !== 1'b0 || nack_log[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL read_nack: got %b%b%b want 001", nack_log[5], nack_log[6], nack_log[7]);
        end
        vectors++;
        if (n_rd !== 3 || rd_log[0] !== 8'h11 || rd_log[1] !== 8'h22 || rd_log[2] !== 8'h33) begin
            miscompares++;
            $display("FAIL read_rdata: n=%0d %h %h %h want 3 11 22 33", n_rd, rd_log[0], rd_log[1], rd_log[2]);
        end
        vectors++;
        if (done_cnt !== 1 || last_status !== 3'd0) begin
            miscompares++; $display("FAIL read_done: cnt=%0d status=%0d want 1/0", done_cnt, last_status);
        end
    endtask

    task automatic test_addr_nack();
        clear_logs();
        ack_tbl[1] = 1'b1;
        wq[0] = 8'h01; wq[1] = 8'h02; wr_n = 2; wr_en = 1'b1;
        start_req(7'h7C, 1'b0, 8'h20, 8'd2);
        wait_done(1);
        vectors++;
        if (n_cmds !== 3 || op_log[0] !== 3'd0 || op_log[1] !== 3'd2 || byte_log[1] !== 8'hF8 || op_log[2] !== 3'd4) begin
            miscompares++;
            $display("FAIL addr_nack_cmds: n=%0d ops=%0d,%0d(%h),%0d want 3 ops=0,2(f8),4",
                     n_cmds, op_log[0], op_log[1], byte_log[1], op_log[2]);
        end
        vectors++;
        if (last_status !== 3'd1 || wr_idx !== 0) begin
            miscompares++;
            $display("FAIL addr_nack_status: status=%0d wdata_taken=%0d want 1/0", last_status, wr_idx);
        end
    endtask

    task automatic test_len_err();
        clear_logs();
        start_req(7'h10, 1'b0, 8'h00, 8'd200);
        @(negedge pclk);
        vectors++;
        if (done !== 1'b1 || status !== 3'd4 || cmd_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_done: done=%b status=%0d cv=%b rr=%b want 1/4/0/0", done, status, cmd_valid, req_ready);
        end
        @(negedge pclk);
        vectors++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL len_err_after: done=%b rr=%b want 0/1", done, req_ready);
        end
        repeat (3) @(posedge pclk);
        vectors++;
        if (n_cmds !== 0) begin
            miscompares++; $display("FAIL len_err_nocmd: n_cmds=%0d want 0", n_cmds);
        end
    endtask

    task automatic test_wdata_stall();
        int bad = 0;
        bit ok = 1'b0;
        clear_logs();
        wq[0] = 8'h5A; wr_n = 1; wr_en = 1'b0;
        start_req(7'h20, 1'b0, 8'h33, 8'd1);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge pclk);
            ok = wdata_ready;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (cmd_valid !== 1'b0 || wdata_ready !== 1'b1) bad++;
        end
        vectors++;
        if (!ok || bad != 0) begin
            miscompares++; $display("FAIL stall_hold: reached=%b bad_cycles=%0d want 1/0", ok, bad);
        end
        @(posedge pclk); #2;
        wr_en = 1'b1;
        wait_done(1);
        exp_add(OP_START, 8'h00); exp_add(OP_WRITE, 8'h40); exp_add(OP_WRITE, 8'h33);
        exp_add(OP_WRITE, 8'h5A); exp_add(OP_STOP, 8'h00);
        vectors++;
        if (n_cmds !== exp_n) begin
            miscompares++; $display("FAIL stall_ncmds: got %0d want %0d", n_cmds, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if (op_log[i] !== exp_op[i] || (exp_op[i] == OP_WRITE && byte_log[i] !== exp_byte[i])) begin
                miscompares++;
                $display("FAIL stall_cmd%0d: got op=%0d byte=%h want op=%0d byte=%h",
                         i, op_log[i], byte_log[i], exp_op[i], exp_byte[i]);
            end
        end
        vectors++;
        if (last_status !== 3'd0) begin
            miscompares++; $display("FAIL stall_status: got %0d want 0", last_status);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_logs();
        start_req(7'h4C, 1'b1, 8'h02, 8'd3);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge pclk);
            ok = n_cmds >= 6;
        end
        #3;
        areset_n = 1'b0;
        hs = 1'b0; rcnt = 0; rsp_valid = 1'b0;
        #1;
        vectors++;
        if (!ok || cmd_valid !== 1'b0 || req_ready !== 1'b1 || rdata_valid !== 1'b0 || done !== 1'b0 ||
            cmd_op !== 3'd0 || wdata_ready !== 1'b0 || cmd_master_nack !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: reached=%b cv=%b rr=%b rv=%b dn=%b op=%0d want 1/0/1/0/0/0",
                     ok, cmd_valid, req_ready, rdata_valid, done, cmd_op);
        end
        repeat (3) @(posedge pclk);
        #3;
        areset_n = 1'b1;
        repeat (5) @(posedge pclk);
        vectors++;
        if (n_cmds !== 6 || done_cnt !== 0) begin
            miscompares++; $display("FAIL midreset_abandon: n_cmds=%0d done=%0d want 6/0", n_cmds, done_cnt);
        end
        clear_logs();
        start_req(7'h11, 1'b0, 8'h44, 8'd0);
        wait_done(1);
        vectors++;
        if (n_cmds !== 4 || op_log[0] !== 3'd0 || byte_log[1] !== 8'h22 || byte_log[2] !== 8'h44 ||
            op_log[3] !== 3'd4 || last_status !== 3'd0) begin
            miscompares++;
            $display("FAIL postreset_len0: n=%0d b1=%h b2=%h op3=%0d st=%0d want 4 22 44 4 0",
                     n_cmds, byte_log[1], byte_log[2], op_log[3], last_status);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start_req(7'h2A, 1'b1, 8'h07, 8'd0);
        wait_done(1);
        vectors++;
        if (n_cmds !== 4 || byte_log[1] !== 8'h54 || byte_log[2] !== 8'h07 || op_log[3] !== 3'd4 ||
            last_status !== 3'd0) begin
            miscompares++;
            $display("FAIL b2b_read_len0: n=%0d b1=%h b2=%h op3=%0d st=%0d want 4 54 07 4 0",
                     n_cmds, byte_log[1], byte_log[2], op_log[3], last_status);
        end
        clear_logs();
        ack_tbl[3] = 1'b1;
        wq[0] = 8'h77; wq[1] = 8'h88; wr_n = 2; wr_en = 1'b1;
        start_req(7'h55, 1'b0, 8'hC3, 8'd2);
        wait_done(1);
        vectors++;
        if (n_cmds !== 5 || byte_log[1] !== 8'hAA || byte_log[2] !== 8'hC3 || byte_log[3] !== 8'h77 ||
            op_log[4] !== 3'd4 || wr_idx !== 1) begin
            miscompares++;
            $display("FAIL b2b_data_nack_cmds: n=%0d b1=%h b2=%h b3=%h op4=%0d taken=%0d want 5 aa c3 77 4 1",
                     n_cmds, byte_log[1], byte_log[2], byte_log[3], op_log[4], wr_idx);
        end
        vectors++;
        if (last_status !== 3'd3 || done_cnt !== 1) begin
            miscompares++; $display("FAIL b2b_data_nack_status: status=%0d cnt=%0d want 3/1", last_status, done_cnt);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_len_err();
        test_wdata_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
